// File: rtl/pipe_pkg.sv
// Shared state encoding and default field widths for the skid-buffered pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int CTRL_W_DEF = 2;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_slot.sv
// One payload slot: load-enabled register that clears asynchronously on reset.
module pipe_slot #(
  parameter int W = 71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // payload storage, captured only when the owning stage selects this slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {W{1'b0}};
    end else if (ld) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage: MAIN drives the outputs, SKID absorbs one beat
// so in_ready never depends on out_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data_a,
  input  logic [DATA_W-1:0] in_data_b,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic [REG_W-1:0]  out_rd,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PL_W = CTRL_W + 2*DATA_W + REG_W;

  state_e            state_r, state_nxt_s;
  logic [PL_W-1:0]   in_pl_s, main_d_s, main_q_s, skid_q_s;
  logic              main_ld_s, skid_ld_s;
  logic              accept_s, drain_s, out_valid_s, in_ready_s;
  logic [CNT_W-1:0]  stall_cnt_r;

  assign in_pl_s     = {in_ctrl, in_data_a, in_data_b, in_rd};
  assign out_valid_s = (state_r != ST_EMPTY);
  assign in_ready_s  = ld & (state_r != ST_TWO);
  assign accept_s    = in_valid & in_ready_s;
  assign drain_s     = out_valid_s & out_ready & ld;

  // occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state and slot load selection; flush wins over everything but reset
  always_comb begin
    state_nxt_s = state_r;
    main_ld_s   = 1'b0;
    skid_ld_s   = 1'b0;
    main_d_s    = in_pl_s;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else if (ld) begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            main_ld_s   = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            main_ld_s = 1'b1;
          end else if (accept_s) begin
            state_nxt_s = ST_TWO;
            skid_ld_s   = 1'b1;
          end else if (drain_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (drain_s) begin
            state_nxt_s = ST_ONE;
            main_ld_s   = 1'b1;
            main_d_s    = skid_q_s;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  pipe_slot #(.W(PL_W)) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (main_ld_s),
    .d   (main_d_s),
    .q   (main_q_s)
  );

  pipe_slot #(.W(PL_W)) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld_s),
    .d   (in_pl_s),
    .q   (skid_q_s)
  );

  // saturating count of cycles where a valid output is held back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_s && !out_ready && ld && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign occupancy  = state_r;
  assign stall_cnt  = stall_cnt_r;
  // a bubble must never carry regwrite/memtoreg downstream
  assign out_ctrl   = out_valid_s ? main_q_s[PL_W-1 -: CTRL_W] : {CTRL_W{1'b0}};
  assign out_data_a = main_q_s[2*DATA_W+REG_W-1 -: DATA_W];
  assign out_data_b = main_q_s[DATA_W+REG_W-1 -: DATA_W];
  assign out_rd     = main_q_s[REG_W-1:0];

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench: queue-based reference model plus directed scenarios and random traffic.
module tb_pipe_skid_stage;

  logic        clk, rst, ld, flush, in_valid, out_ready;
  logic [1:0]  in_ctrl;
  logic [31:0] in_data_a, in_data_b;
  logic [4:0]  in_rd;

  logic        in_ready, out_valid;
  logic [1:0]  out_ctrl, occupancy;
  logic [31:0] out_data_a, out_data_b;
  logic [4:0]  out_rd;
  logic [15:0] stall_cnt;

  logic        in_ready2, out_valid2;
  logic [1:0]  out_ctrl2, occupancy2, stall_cnt2;
  logic [31:0] out_data_a2, out_data_b2;
  logic [4:0]  out_rd2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } ent_t;

  ent_t        q[$];
  int unsigned cnt_m, cnt2_m;
  int          m_sz;
  logic        m_acc, m_drn;
  logic [31:0] vals [3];

  pipe_skid_stage dut (
    .clk(clk), .rst(rst), .ld(ld), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data_a(in_data_a), .in_data_b(in_data_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data_a(out_data_a), .out_data_b(out_data_b), .out_rd(out_rd),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ld(ld), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data_a(in_data_a), .in_data_b(in_data_b), .in_rd(in_rd),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_ctrl(out_ctrl2), .out_data_a(out_data_a2), .out_data_b(out_data_b2), .out_rd(out_rd2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two entries, updated at every clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cnt_m  = 0;
      cnt2_m = 0;
    end else begin
      m_sz  = q.size();
      m_acc = in_valid && ld && (m_sz < 2);
      m_drn = (m_sz > 0) && out_ready && ld;
      if ((m_sz > 0) && !out_ready && ld) begin
        if (cnt_m < 65535) cnt_m++;
        if (cnt2_m < 3) cnt2_m++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (m_drn) void'(q.pop_front());
        if (m_acc) q.push_back('{in_ctrl, in_data_a, in_data_b, in_rd});
      end
    end
  end

  // Compare both DUTs against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("occupancy2", 64'(occupancy2), 64'(q.size()));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("out_valid2", 64'(out_valid2), 64'(q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(ld && (q.size() < 2)));
      check("in_ready2", 64'(in_ready2), 64'(ld && (q.size() < 2)));
      check("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
      check("stall_cnt2", 64'(stall_cnt2), 64'(cnt2_m));
      if (q.size() != 0) begin
        check("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
        check("out_data_a", 64'(out_data_a), 64'(q[0].a));
        check("out_data_b", 64'(out_data_b), 64'(q[0].b));
        check("out_rd", 64'(out_rd), 64'(q[0].rd));
        check("out_data_a2", 64'(out_data_a2), 64'(q[0].a));
        check("out_ctrl2", 64'(out_ctrl2), 64'(q[0].c));
        check("out_data_b2", 64'(out_data_b2), 64'(q[0].b));
        check("out_rd2", 64'(out_rd2), 64'(q[0].rd));
      end else begin
        check("bubble_ctrl", 64'(out_ctrl), 64'd0);
        check("bubble_ctrl2", 64'(out_ctrl2), 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; ld = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = 2'b00; in_data_a = 32'd0; in_data_b = 32'd0; in_rd = 5'd0;
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;

    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_data_a", 64'(out_data_a), 64'd0);
    rst = 1'b0; ld = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);

    // streaming with a ready sink: one-cycle latency, occupancy stays 1
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 2'b01;
    for (int i = 0; i < 3; i++) begin
      in_data_a = vals[i]; in_data_b = 32'h100 + i; in_rd = 5'(i + 1);
      step();
      check("stream_data_a", 64'(out_data_a), 64'(vals[i]));
      check("stream_occ", 64'(occupancy), 64'd1);
      check("stream_stall", 64'(stall_cnt), 64'd0);
    end
    in_valid = 1'b0;
    step();
    check("stream_empty", 64'(occupancy), 64'd0);

    // blocked sink fills both slots, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_data_a = 32'hA;
    step();
    in_data_a = 32'hB;
    step();
    check("fill_occ", 64'(occupancy), 64'd2);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_stall", 64'(stall_cnt), 64'd1);
    in_valid = 1'b0;
    step();
    check("fill_stall2", 64'(stall_cnt), 64'd2);
    check("drain_first", 64'(out_data_a), 64'hA);
    out_ready = 1'b1;
    step();
    check("drain_second", 64'(out_data_a), 64'hB);
    check("drain_occ", 64'(occupancy), 64'd1);
    check("drain_stall", 64'(stall_cnt), 64'd2);
    step();
    check("drain_empty", 64'(occupancy), 64'd0);

    // flush while full and frozen
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_data_a = 32'hC;
    step();
    in_data_a = 32'hD;
    step();
    check("pre_flush_occ", 64'(occupancy), 64'd2);
    check("pre_flush_ctrl", 64'(out_ctrl), 64'd3);
    flush = 1'b1; ld = 1'b0;
    step();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_stall", 64'(stall_cnt), 64'd3);
    flush = 1'b0; ld = 1'b1;

    // freeze with ld=0: nothing accepted or drained
    in_data_a = 32'hE; in_ctrl = 2'b01;
    step();
    ld = 1'b0; in_data_a = 32'hF; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("freeze_occ", 64'(occupancy), 64'd1);
      check("freeze_data", 64'(out_data_a), 64'hE);
      check("freeze_stall", 64'(stall_cnt), 64'd3);
      check("freeze_in_ready", 64'(in_ready), 64'd0);
    end
    ld = 1'b1; in_valid = 1'b0;
    step();
    check("unfreeze_empty", 64'(occupancy), 64'd0);

    // asynchronous reset pulse in the middle of a cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data_a = 32'h55;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    check("arst_ctrl", 64'(out_ctrl), 64'd0);
    check("arst_data", 64'(out_data_a), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);

    // stall counter saturation on the narrow instance
    in_valid = 1'b1; in_data_a = 32'h66;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    check("sat_stall2", 64'(stall_cnt2), 64'd3);
    check("sat_stall", 64'(stall_cnt), 64'd6);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ld        = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      in_ctrl   = 2'($urandom);
      in_data_a = $urandom;
      in_data_b = $urandom;
      in_rd     = 5'($urandom);
      step();
    end
    ld = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("final_empty", 64'(occupancy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
- Parameters (name, default, meaning):
REQ-001 SHALL provide DATA_W, 32, width of each data payload field.
REQ-002 SHALL provide REG_W, 5, width of destination-register field.
REQ-003 SHALL provide CTRL_W, 2, width of control field (bit 0 = regwrite, bit 1 = memtoreg).
REQ-004 SHALL provide CNT_W, 16, width of stall counter.
- Ports (name, direction, width, meaning):
REQ-005 SHALL provide clk, input, 1, single clock, rising edge.
REQ-006 SHALL provide rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL provide ld, input, 1, global stage enable; 0 freezes the stage.
REQ-008 SHALL provide flush, input, 1, synchronous squash of all held entries.
REQ-009 SHALL provide in_valid, input, 1; in_ready, output, 1; upstream handshake.
REQ-010 SHALL provide in_ctrl, input, CTRL_W; in_data_a, input, DATA_W; in_data_b, input, DATA_W; in_rd, input, REG_W; upstream payload.
REQ-011 SHALL provide out_valid, output, 1; out_ready, input, 1; downstream handshake.
REQ-012 SHALL provide out_ctrl, output, CTRL_W; out_data_a, output, DATA_W; out_data_b, output, DATA_W; out_rd, output, REG_W; downstream payload.
REQ-013 SHALL provide occupancy, output, 2, number of held entries (0..2).
REQ-014 SHALL provide stall_cnt, output, CNT_W, cycles with out_valid=1 and drain blocked.

Function
REQ-015 SHALL hold two payload slots, MAIN (drives outputs) and SKID, and track state EMPTY, ONE or TWO.
REQ-016 SHALL drive in_ready = ld AND (state != TWO), with no dependence on out_ready.
REQ-017 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready & ld.
REQ-018 SHALL, in EMPTY, go to ONE on accept with MAIN <= input; otherwise stay in EMPTY.
REQ-019 SHALL, in ONE: accept & drain -> stay ONE, MAIN <= input; accept & ~drain -> TWO, SKID <= input; ~accept & drain -> EMPTY.
REQ-020 SHALL, in TWO, go to ONE on drain with MAIN <= SKID; accept is impossible in TWO.
REQ-021 SHALL give one-cycle latency: data accepted into EMPTY appears on outputs the next cycle.
REQ-022 SHALL, when ld=0, leave state, slots and stall_cnt unchanged, except for flush and rst.
REQ-023 SHALL, on flush=1 at a clock edge, enter EMPTY regardless of ld, in_valid or out_ready; that cycle's input is discarded.
REQ-024 SHALL force out_ctrl to all-zero whenever out_valid=0 (bubble never writes the register file); the other payload outputs are don't-care then.
REQ-025 SHALL drive out_valid = (state != EMPTY) and occupancy = 0/1/2 for EMPTY/ONE/TWO.
REQ-026 SHALL increment stall_cnt by one when out_valid & ~out_ready & ld, saturate at all-ones, and clear it only on rst.
REQ-027 SHALL never drop or duplicate an accepted entry and SHALL preserve FIFO order.

Reset
REQ-028 SHALL, while rst=1, immediately force state EMPTY, all slot payloads 0, stall_cnt 0, out_valid 0 and occupancy 0.
REQ-029 SHALL make in_ready = ld after reset release; rst overrides flush and ld.
REQ-030 SHALL, on rst asserted mid-transfer, lose held entries without a partial update on the releasing edge.

Structure
REQ-031 SHALL place the state encoding (EMPTY=0, ONE=1, TWO=2) and the default widths in a shared package pipe_pkg.
REQ-032 SHALL implement each slot with one sub-module, pipe_slot: a load-enabled register of CTRL_W+2*DATA_W+REG_W bits with asynchronous reset, instantiated twice.

Verification
REQ-033 SHALL check: rst pulse mid-cycle -> all outputs 0 at once; after release with ld=1, in_ready=1.
REQ-034 SHALL check: out_ready=1, stream in_data_a=0x11,0x22,0x33 -> the same values on out_data_a one cycle later each, occupancy constant 1, stall_cnt 0.
REQ-035 SHALL check: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0; raise out_ready -> 0xA then 0xB out in order, and stall_cnt counts the blocked cycles exactly.
REQ-036 SHALL check: occupancy 2 with flush=1 and ld=0 -> next cycle EMPTY, out_valid=0, out_ctrl=2'b00, in_ready=0.
REQ-037 SHALL check: ld=0 for 5 cycles with in_valid=1 -> no accept, outputs frozen, stall_cnt unchanged.
REQ-038 SHALL check: CNT_W=2 with out_ready=0 held for 6 cycles -> stall_cnt saturates at 3.
